ahb_slave_pipe: RTL
===================

// Module: ahb_slave_pipe
// PURPOSE
//  AHB-side front end of the AHB-to-APB bridge; sits directly upstream of the APB control FSM.
//  - Qualifies AHB transfers into a single `valid` strobe.
//  - Decodes the target peripheral into a one-hot `tempselx`.
//  - Provides a two-deep address/data/write pipeline (Haddr1/2, Hwdata1/2, Hwritereg) for pipelined writes.
//  - Returns read data from the APB side to the AHB master.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  base address of the peripheral window
//  SLOT_SIZE  32'h0000_0400  bytes per peripheral slot; slot count fixed at 3
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   reset, synchronous, active-low
//  Hwrite     in   1   AHB write (1) / read (0)
//  Hreadyin   in   1   AHB HREADY from system mux; gates all captures
//  Htrans     in   2   AHB HTRANS
//  Haddr      in   32  AHB address
//  Hwdata     in   32  AHB write data
//  Prdata     in   32  APB read data
//  valid      out  1   qualified, mapped transfer in current address phase
//  Haddr1     out  32  address delayed 1 accepted cycle
//  Haddr2     out  32  address delayed 2 accepted cycles
//  Hwdata1    out  32  write data delayed 1 accepted cycle
//  Hwdata2    out  32  write data delayed 2 accepted cycles
//  Hwritereg  out  1   Hwrite delayed 1 accepted cycle
//  tempselx   out  3   one-hot slot select from current Haddr
//  Hrdata     out  32  = Prdata, combinational pass-through
//  Hresp      out  2   AHB response; 2'b00 OKAY, 2'b01 ERROR
//  err_hready out  1   stall from error response; top ANDs it with bridge Hreadyout
// BEHAVIOUR
//  Reset (rst=0 at clk edge):
//   - Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg <= 0.
//   - Error FSM <= OKAY, so Hresp=2'b00 and err_hready=1.
//  Pipeline, when rst=1 and Hreadyin=1:
//   - Haddr2<=Haddr1; Haddr1<=Haddr; Hwdata2<=Hwdata1; Hwdata1<=Hwdata; Hwritereg<=Hwrite.
//   - Hreadyin=0: all pipeline registers hold.
//   - Capture is independent of Htrans and of mapping.
//  Decode, combinational from current Haddr:
//   - off = Haddr-BASE_ADDR.
//   - tempselx = 3'b001 for off in [0,SLOT); 3'b010 for [SLOT,2*SLOT); 3'b100 for [2*SLOT,3*SLOT); else 3'b000.
//   - Haddr < BASE_ADDR or Haddr >= BASE_ADDR+3*SLOT_SIZE -> unmapped; the upper bound is exclusive.
//   - The subtraction uses a 33-bit compare, so no wrap-around false hit.
//  valid = Hreadyin & Htrans[1] & mapped. Htrans[1]=1 means NONSEQ or SEQ; IDLE and BUSY give valid=0.
//   - Combinational; zero latency to the bridge next-state logic.
//   - Forced 0 while rst=0.
// CONFIGURATION
//  AHB_SLV_ERR_RESP_EN defined: 3-state error FSM {OKAY, ERR1, ERR2}.
//   - OKAY: Hreadyin & Htrans[1] & unmapped -> ERR1; else stay.
//   - ERR1: Hresp=01, err_hready=0; unconditionally -> ERR2; inputs ignored.
//   - ERR2: Hresp=01, err_hready=1.
//     - A new unmapped active transfer with Hreadyin=1 -> ERR1 (back-to-back errors).
//     - Anything else -> OKAY.
//   - OKAY: Hresp=00, err_hready=1.
//   - Outputs decode from registered state only.
//   - rst=0 in any state -> OKAY next edge.
//  AHB_SLV_ERR_RESP_EN undefined:
//   - No error FSM; Hresp tied 2'b00, err_hready tied 1.
//   - Unmapped transfers are silently dropped (valid=0).
// STRUCTURE
//  Package ahb_apb_pkg:
//   - HTRANS codes IDLE/BUSY/NONSEQ/SEQ; HRESP codes OKAY/ERROR.
//   - Default BASE_ADDR/SLOT_SIZE; NUM_SLOTS=3.
//   - Error-FSM state encoding.
//  Sub-module ahb_addr_decode: combinational Haddr -> {mapped, tempselx}.
//  Pipeline and error FSM stay in this module.
// TESTING
//  1. Reset: rst=0 for 2 cycles with Hreadyin=1, Htrans=2'b10, Haddr=8000_0004.
//     -> all pipeline regs 0, valid=0, Hresp=00, err_hready=1.
//  2. Write NONSEQ Haddr=8000_0004, Hwrite=1, Hwdata=A5A5_0001, Hreadyin=1.
//     -> valid=1, tempselx=001.
//     -> +1 clk: Haddr1=8000_0004, Hwdata1=A5A5_0001, Hwritereg=1.
//     -> +2 clk: Haddr2=8000_0004, Hwdata2=A5A5_0001.
//  3. Read NONSEQ Haddr=8000_0800 -> valid=1, tempselx=100.
//     Same address with Htrans=01 (BUSY) -> valid=0.
//     Haddr=8000_0C00 -> tempselx=000, valid=0.
//  4. Hreadyin=0 for 3 cycles, Haddr stepping 8000_0000/04/08 -> Haddr1, Haddr2, Hwdata1, Hwritereg unchanged.
//     Hreadyin=1 -> capture resumes; Prdata=1234_5678 -> Hrdata=1234_5678 same cycle.
//  5. Macro on: NONSEQ Haddr=7FFF_FFFC.
//     -> +1 clk: Hresp=01, err_hready=0.
//     -> +2 clk: Hresp=01, err_hready=1.
//     -> +3 clk: OKAY.
//     Macro off: Hresp=00, err_hready=1 throughout.
//  6. Macro on: enter ERR1, drop rst=0 for 1 cycle -> Hresp=00, err_hready=1 the following cycle.
//     Back-to-back unmapped in ERR2 -> ERR1 again.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared constants for the AHB-to-APB bridge: bus encodings, default peripheral window, error-FSM states.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEF_SLOT_SIZE = 32'h0000_0400;
    localparam int          NUM_SLOTS     = 3;

    localparam logic [1:0] ERR_OKAY = 2'd0;
    localparam logic [1:0] ERR_ERR1 = 2'd1;
    localparam logic [1:0] ERR_ERR2 = 2'd2;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational peripheral decode: current AHB address to {mapped, one-hot slot select}.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] SLOT_SIZE = DEF_SLOT_SIZE
) (
    input  logic [31:0]          haddr,
    output logic                 mapped,
    output logic [NUM_SLOTS-1:0] tempselx
);

    localparam logic [33:0] SLOT_1 = {2'b00, SLOT_SIZE};
    localparam logic [33:0] SLOT_2 = SLOT_1 + SLOT_1;
    localparam logic [33:0] SLOT_3 = SLOT_2 + SLOT_1;

    // Widened subtraction: an address below the base sets the top bit instead of wrapping into a slot.
    logic [33:0] off;
    assign off = {2'b00, haddr} - {2'b00, BASE_ADDR};

    always_comb begin
        tempselx = '0;
        if (!off[33]) begin
            if (off < SLOT_1) begin
                tempselx = 3'b001;
            end else if (off < SLOT_2) begin
                tempselx = 3'b010;
            end else if (off < SLOT_3) begin
                tempselx = 3'b100;
            end
        end
    end

    assign mapped = |tempselx;

endmodule

// File: rtl/ahb_slave_pipe.sv
// AHB front end of the AHB-to-APB bridge: transfer qualify, slot decode, two-deep capture pipeline.
// Optional error response FSM enabled by defining AHB_SLV_ERR_RESP_EN.
module ahb_slave_pipe
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] SLOT_SIZE = DEF_SLOT_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Hwrite,
    input  logic                 Hreadyin,
    input  logic [1:0]           Htrans,
    input  logic [31:0]          Haddr,
    input  logic [31:0]          Hwdata,
    input  logic [31:0]          Prdata,
    output logic                 valid,
    output logic [31:0]          Haddr1,
    output logic [31:0]          Haddr2,
    output logic [31:0]          Hwdata1,
    output logic [31:0]          Hwdata2,
    output logic                 Hwritereg,
    output logic [NUM_SLOTS-1:0] tempselx,
    output logic [31:0]          Hrdata,
    output logic [1:0]           Hresp,
    output logic                 err_hready
);

    logic mapped;
    logic active;

    ahb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SLOT_SIZE (SLOT_SIZE)
    ) u_decode (
        .haddr    (Haddr),
        .mapped   (mapped),
        .tempselx (tempselx)
    );

    // NONSEQ and SEQ both have bit 1 set; bit 0 only distinguishes them.
    assign active = Hreadyin & Htrans[1];
    assign valid  = rst & active & mapped;
    assign Hrdata = Prdata;

    // Capture ignores Htrans and mapping so the bridge always sees the last accepted phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr2    <= Haddr1;
            Haddr1    <= Haddr;
            Hwdata2   <= Hwdata1;
            Hwdata1   <= Hwdata;
            Hwritereg <= Hwrite;
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    // state    | meaning
    // ERR_OKAY | no error in progress, OKAY response
    // ERR_ERR1 | first error cycle, ERROR with HREADY low
    // ERR_ERR2 | second error cycle, ERROR with HREADY high
    logic [1:0] err_state;
    logic [1:0] err_next;
    logic       err_hit;

    assign err_hit = active & ~mapped;

    always_comb begin
        err_next = err_state;
        case (err_state)
            ERR_OKAY: if (err_hit) err_next = ERR_ERR1;
            ERR_ERR1: err_next = ERR_ERR2;
            ERR_ERR2: err_next = err_hit ? ERR_ERR1 : ERR_OKAY;
            default:  err_next = ERR_OKAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_state <= ERR_OKAY;
        end else begin
            err_state <= err_next;
        end
    end

    assign Hresp      = (err_state == ERR_ERR1 || err_state == ERR_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign err_hready = (err_state != ERR_ERR1);
`else
    assign Hresp      = HRESP_OKAY;
    assign err_hready = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = Htrans[0];

endmodule
